ifm_pingpong_buf: RTL and testbench
===================================

# ifm_pingpong_buf

- Double-banked (ping-pong) input-feature-map buffer between the AXI IFM read master and the convolution datapath.
- Write side: takes the master's buffer write port (wr_en/wr_addr/wr_data) plus its done pulse. Read side: gives the compute engine one full bank at a time.
- Filling one bank overlaps with draining the other.
- Tracks per-bank occupancy, word count, and overflow/underflow errors.

## Interface

Parameters:
- DATA_W, 128, word width; equals the AXI data width of the IFM master.
- ADDR_W, 10, bank address width; each bank holds 2^ADDR_W words.

Ports:
- clk, in, 1, sole clock; all logic on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- wr_en, in, 1, write strobe from the IFM master.
- wr_addr, in, ADDR_W, word address within the current write bank.
- wr_data, in, DATA_W, write word.
- wr_done, in, 1, one-cycle pulse: the current write bank is complete; commit it.
- wr_ready, out, 1, current write bank is not FULL; the controller gates start_read on this.
- rd_en, in, 1, read strobe from compute.
- rd_addr, in, ADDR_W, word address within the current read bank.
- rd_data, out, DATA_W, read word, registered.
- rd_valid, out, 1, rd_data valid; exactly one cycle after an accepted rd_en.
- rd_avail, out, 1, current read bank is FULL.
- rd_len, out, ADDR_W+1, word count committed in the current read bank.
- rd_release, in, 1, one-cycle pulse: compute is finished with the read bank.
- wr_bank, out, 1, index of the current write bank.
- rd_bank, out, 1, index of the current read bank.
- err_ovf, out, 1, sticky overflow flag.
- err_udf, out, 1, sticky underflow flag.
- err_clr, in, 1, synchronous clear of both error flags.

## Operation

- **Bank state**, per bank, 2 bits:
  - EMPTY -> FILLING on the first accepted write.
  - EMPTY or FILLING -> FULL on wr_done.
  - FULL -> EMPTY on rd_release.
- **Write pointer:** wr_bank toggles on every accepted wr_done.
- **Read pointer:** rd_bank toggles on every accepted rd_release.
- **Write acceptance:** a write is accepted when wr_en=1 and state[wr_bank] != FULL. The word goes to mem[wr_bank][wr_addr].
- **Word counter:** len[wr_bank] increments per accepted write and saturates at 2^ADDR_W. It clears when the bank enters EMPTY.
- **Count semantics:** len counts strobes, not distinct addresses.
- **Dropped write:** wr_en=1 while state[wr_bank]=FULL drops the data and sets err_ovf.
- **wr_done:**
  - On an EMPTY bank: accepted; the bank becomes FULL with len=0.
  - On a FULL bank: ignored; sets err_ovf.
- **Write and wr_done in the same cycle:** the write lands first; the committed len includes it.
- **Read acceptance:** a read is accepted when rd_en=1 and state[rd_bank]=FULL. rd_data gets mem[rd_bank][rd_addr] and rd_valid=1 on the next cycle.
- **Rejected read:** rd_en with the read bank not FULL leaves rd_valid=0, leaves rd_data unchanged, and sets err_udf.
- **rd_release:** on a non-FULL bank it is ignored and sets err_udf.
- **wr_done and rd_release in the same cycle:** they hit different banks, or one is rejected; both accepted effects apply.
- **Error flags:** err_clr clears both flags. A new error event in the same cycle wins, so the flag stays 1.
- **Reset values:**
  - Both banks EMPTY; both len=0.
  - wr_bank=0, rd_bank=0.
  - rd_data=0, rd_valid=0.
  - err_ovf=0, err_udf=0.
  - Memory contents are not reset.
- **Derived outputs:** wr_ready=1 and rd_avail=0 immediately after reset.
- **Reset mid-operation:** any fill or drain in progress is discarded. In-flight rd_valid drops asynchronously.

## Timing

- wr_ready, rd_avail and rd_len are combinational from registered state. No input-to-output combinational path.
- Read latency is 1 cycle: rd_en at edge N gives rd_data/rd_valid after edge N+1. Back-to-back reads sustain 1 word/cycle.
- wr_done sampled at edge N:
  - state FULL and wr_bank toggled after N.
  - rd_avail=1 from N+1 if that bank is rd_bank.
- rd_release sampled at edge N: the bank is EMPTY and wr_ready reflects it from N+1.
- A read accepted in the same cycle as rd_release still returns valid data from the old bank on the next cycle.
- Each bank is one simple-dual-port RAM: write port from the write side, registered read port.

## Test plan

- **Fill and commit:** reset; write 128 words (data = addr) to bank 0; pulse wr_done -> rd_avail=1, rd_len=128, wr_bank=1, rd_bank=0.
- **Read back:** reads addr 0..127 -> rd_valid one cycle after each rd_en, rd_data=addr. rd_release -> bank 0 EMPTY, rd_bank=1.
- **Overlap:** fill bank 1 while draining bank 0, with wr_done and rd_release in the same cycle -> both banks change state, both pointers toggle, no error flags.
- **Overflow:** fill and commit both banks, then wr_en -> err_ovf=1, wr_ready=0, memory unchanged. err_clr -> err_ovf=0.
- **Underflow:** rd_en with rd_avail=0 -> rd_valid stays 0, err_udf=1. rd_release with no FULL bank -> ignored, pointers unchanged.
- **Reset mid-fill:** assert rst after 40 writes -> all outputs return to reset values asynchronously; next fill starts in bank 0 with len=0.

Source files
------------

// File: rtl/ifm_pingpong_buf.sv
// Double-banked IFM buffer: the AXI read master fills one bank while the convolution
// datapath drains the other. Tracks per-bank state, word count and sticky error flags.
module ifm_pingpong_buf #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_avail,
  output logic [ADDR_W:0]   rd_len,
  input  logic              rd_release,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              err_clr
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'b00,
    BANK_FILLING = 2'b01,
    BANK_FULL    = 2'b10
  } bank_state_e;

  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic [ADDR_W:0]   len_q   [2];
  logic [ADDR_W:0]   len_d   [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;

  logic [DATA_W-1:0] mem [2][DEPTH];

  logic wr_full, rd_full;
  logic wr_accept, done_accept, rd_accept, rel_accept;
  logic ovf_event, udf_event;

  // Acceptance is decided purely from registered bank state. A wr_done and an
  // rd_release can only both be accepted when they address different banks.
  assign wr_full     = (state_q[wr_ptr_q] == BANK_FULL);
  assign rd_full     = (state_q[rd_ptr_q] == BANK_FULL);
  assign wr_accept   = wr_en & ~wr_full;
  assign done_accept = wr_done & ~wr_full;
  assign rd_accept   = rd_en & rd_full;
  assign rel_accept  = rd_release & rd_full;
  assign ovf_event   = (wr_en | wr_done) & wr_full;
  assign udf_event   = (rd_en | rd_release) & ~rd_full;

  // NOTE: every signal driven here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      len_d[b]   = len_q[b];
    end
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    // A write in the same cycle as wr_done lands first, so the committed count includes it.
    if (wr_accept) begin
      if (len_q[wr_ptr_q] != LEN_MAX) begin
        len_d[wr_ptr_q] = len_q[wr_ptr_q] + LEN_ONE;
      end
      if (state_q[wr_ptr_q] == BANK_EMPTY) begin
        state_d[wr_ptr_q] = BANK_FILLING;
      end
    end

    if (done_accept) begin
      state_d[wr_ptr_q] = BANK_FULL;
      wr_ptr_d          = ~wr_ptr_q;
    end

    if (rel_accept) begin
      state_d[rd_ptr_q] = BANK_EMPTY;
      len_d[rd_ptr_q]   = '0;
      rd_ptr_d          = ~rd_ptr_q;
    end

    // A fresh error event outranks err_clr in the same cycle.
    err_ovf_d = (err_ovf_q & ~err_clr) | ovf_event;
    err_udf_d = (err_udf_q & ~err_clr) | udf_event;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BANK_EMPTY;
        len_q[b]   <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        len_q[b]   <= len_d[b];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  // NOTE: the bank RAMs are deliberately not reset; contents only matter once written, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q][wr_addr] <= wr_data;
    end
  end

  // Registered read port. The write bank is never FULL and the read bank must be,
  // so a read and a write never collide on the same bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= mem[rd_ptr_q][rd_addr];
      end
    end
  end

  assign wr_ready = ~wr_full;
  assign rd_avail = rd_full;
  assign rd_len   = len_q[rd_ptr_q];
  assign wr_bank  = wr_ptr_q;
  assign rd_bank  = rd_ptr_q;
  assign err_ovf  = err_ovf_q;
  assign err_udf  = err_udf_q;

endmodule

// File: tb/tb_ifm_pingpong_buf.sv
// Self-checking bench for ifm_pingpong_buf: directed scenarios plus random traffic,
// read data checked through a scoreboard fed by a bank-level reference model.
module tb_ifm_pingpong_buf;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_avail;
  logic [ADDR_W:0]   rd_len;
  logic              rd_release;
  logic              wr_bank;
  logic              rd_bank;
  logic              err_ovf;
  logic              err_udf;
  logic              err_clr;

  always #5 clk = ~clk;

  ifm_pingpong_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_avail   (rd_avail),
    .rd_len     (rd_len),
    .rd_release (rd_release),
    .wr_bank    (wr_bank),
    .rd_bank    (rd_bank),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf),
    .err_clr    (err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bank is either committed (full) or not; contents kept sparsely.
  typedef struct {
    bit                known;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb_q [$];
  logic [DATA_W-1:0] m_mem [int];
  bit                m_full [2];
  int                m_len  [2];
  bit                m_wb, m_rb, m_ovf, m_udf;
  logic [DATA_W-1:0] m_rd_data;
  bit                m_rd_known;

  function automatic void model_reset();
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_len[0]  = 0;    m_len[1]  = 0;
    m_wb = 1'b0; m_rb = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    m_rd_data = '0; m_rd_known = 1'b1;
    sb_q.delete();
  endfunction

  // Apply one clock's worth of the buffer rules to the currently driven inputs.
  function automatic void model_step();
    bit wfull  = m_full[m_wb];
    bit rfull  = m_full[m_rb];
    bit w_ok   = wr_en && !wfull;
    bit d_ok   = wr_done && !wfull;
    bit r_ok   = rd_en && rfull;
    bit rel_ok = rd_release && rfull;
    int key;
    exp_t e;
    m_ovf = (m_ovf && !err_clr) || ((wr_en || wr_done) && wfull);
    m_udf = (m_udf && !err_clr) || ((rd_en || rd_release) && !rfull);
    if (r_ok) begin
      key = int'(m_rb) * DEPTH + int'(rd_addr);
      e.known = m_mem.exists(key);
      e.data  = e.known ? m_mem[key] : '0;
      sb_q.push_back(e);
      m_rd_known = e.known;
      m_rd_data  = e.data;
    end
    if (w_ok) begin
      m_mem[int'(m_wb) * DEPTH + int'(wr_addr)] = wr_data;
      if (m_len[m_wb] < DEPTH) m_len[m_wb]++;
    end
    if (d_ok) begin
      m_full[m_wb] = 1'b1;
      m_wb = !m_wb;
    end
    if (rel_ok) begin
      m_full[m_rb] = 1'b0;
      m_len[m_rb]  = 0;
      m_rb = !m_rb;
    end
  endfunction

  // Monitor: every rd_valid must match the oldest expected read.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        check("rd_valid_unexpected", rd_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        if (e.known) check("rd_data", rd_data, e.data);
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, ".wr_ready"}, wr_ready, !m_full[m_wb]);
    check({tag, ".rd_avail"}, rd_avail, m_full[m_rb]);
    check({tag, ".rd_len"},   rd_len,   m_len[m_rb]);
    check({tag, ".wr_bank"},  wr_bank,  m_wb);
    check({tag, ".rd_bank"},  rd_bank,  m_rb);
    check({tag, ".err_ovf"},  err_ovf,  m_ovf);
    check({tag, ".err_udf"},  err_udf,  m_udf);
  endtask

  task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic wdn, input logic re, input logic [ADDR_W-1:0] ra,
                      input logic rel, input logic clr);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_done = wdn;
    rd_en = re; rd_addr = ra; rd_release = rel; err_clr = clr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_release = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_status("reset");
    check("reset.rd_valid", rd_valid, 1'b0);
    check("reset.rd_data",  rd_data,  '0);
    rst = 1'b0;
    @(negedge clk); #1;
    check_status("post_reset");

    // Fill bank 0 with data = addr and commit.
    for (int a = 0; a < 128; a++) step(1'b1, ADDR_W'(a), DATA_W'(a), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_status("commit0");
    check("commit0.rd_avail", rd_avail, 1'b1);
    check("commit0.rd_len",   rd_len,   128);
    check("commit0.wr_bank",  wr_bank,  1'b1);
    check("commit0.rd_bank",  rd_bank,  1'b0);

    // Back-to-back read-back of bank 0, then release.
    for (int a = 0; a < 128; a++) step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(a), 1'b0, 1'b0);
    idle();
    check("readback.drained", sb_q.size(), 0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_status("release0");
    check("release0.rd_bank", rd_bank, 1'b1);

    // Overlap: fill bank 1, then drain it while filling bank 0; final cycle has
    // write, wr_done, read and rd_release together.
    for (int a = 0; a < 64; a++) step(1'b1, ADDR_W'(a), rand_data(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int a = 0; a < 64; a++)
      step(1'b1, ADDR_W'(a), rand_data(), a == 63, 1'b1, ADDR_W'(63 - a), a == 63, 1'b0);
    check_status("overlap");
    check("overlap.wr_bank", wr_bank, 1'b1);
    check("overlap.rd_bank", rd_bank, 1'b0);
    check("overlap.rd_len",  rd_len,  64);
    check("overlap.err_ovf", err_ovf, 1'b0);
    check("overlap.err_udf", err_udf, 1'b0);
    idle();

    // Overflow: commit bank 1 too, then write and wr_done into a full bank.
    for (int a = 0; a < 16; a++) step(1'b1, ADDR_W'(a), rand_data(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("ovf.wr_ready_before", wr_ready, 1'b0);
    step(1'b1, ADDR_W'(5), {DATA_W/16{16'hdead}}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_status("ovf_write");
    check("ovf.err_ovf", err_ovf, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_status("ovf_done");
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(5), 1'b0, 1'b0);  // memory must hold old word
    step(1'b1, ADDR_W'(6), rand_data(), 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("ovf.clr_vs_event", err_ovf, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("ovf.cleared", err_ovf, 1'b0);

    // Underflow: release both banks, then read and release with nothing committed.
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_status("udf_empty");
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(3), 1'b0, 1'b0);
    check("udf.rd_valid", rd_valid, 1'b0);
    check("udf.err_udf",  err_udf,  1'b1);
    if (m_rd_known) check("udf.rd_data_held", rd_data, m_rd_data);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_status("udf_release");
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("udf.cleared", err_udf, 1'b0);

    // wr_done on an empty bank commits len 0; write plus wr_done commits len 1.
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_status("empty_commit");
    check("empty_commit.rd_len", rd_len, 0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, ADDR_W'(3), rand_data(), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_status("write_and_done");
    check("write_and_done.rd_len", rd_len, 1);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(3), 1'b1, 1'b0);

    // Count saturation: more strobes than the bank holds.
    for (int i = 0; i < DEPTH + 3; i++)
      step(1'b1, ADDR_W'($urandom_range(DEPTH - 1)), rand_data(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_status("saturate");
    check("saturate.rd_len", rd_len, DEPTH);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Random traffic on a small address window so reads mostly hit written words.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(3) != 0, ADDR_W'($urandom_range(31)), rand_data(),
           $urandom_range(15) == 0, $urandom_range(1) == 1, ADDR_W'($urandom_range(31)),
           $urandom_range(19) == 0, $urandom_range(24) == 0);
      check_status("rand");
    end
    idle();
    idle();
    check("rand.drained", sb_q.size(), 0);

    // Reset mid-fill with a read in flight.
    rst = 1'b1;
    model_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) step(1'b1, ADDR_W'(a), rand_data(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int a = 0; a < 40; a++)
      step(1'b1, ADDR_W'(a), rand_data(), 1'b0, 1'b1, ADDR_W'(a % 8), 1'b0, 1'b0);
    check("pre_rst.rd_valid", rd_valid, 1'b1);
    check("pre_rst.rd_len",   rd_len,   8);
    rst = 1'b1;
    model_reset();
    #1;
    check_status("async_rst");
    check("async_rst.rd_valid", rd_valid, 1'b0);
    check("async_rst.rd_data",  rd_data,  '0);
    @(negedge clk); #1;
    rst = 1'b0;
    for (int a = 0; a < 10; a++) step(1'b1, ADDR_W'(a), rand_data(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_status("refill");
    check("refill.rd_len",  rd_len,  10);
    check("refill.wr_bank", wr_bank, 1'b1);
    check("refill.rd_bank", rd_bank, 1'b0);
    for (int a = 0; a < 10; a++) step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(a), 1'b0, 1'b0);
    idle();
    idle();
    check("final.drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
